// File: rtl/lenia_pkg.sv
// Shared definitions for the Lenia convolution sweep: FSM encoding,
// sweep counter width and default world parameters.
package lenia_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  localparam int unsigned SWEEP_CNT_W     = 16;
  localparam int unsigned DEFAULT_SIZE    = 8;
  localparam int unsigned DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/lenia_raster_counter.sv
// Raster-order (i, j) position register for the sweep, with the flat
// result-buffer address and a last-cell flag kept alongside.
module lenia_raster_counter
  import lenia_pkg::*;
#(
  parameter int unsigned SIZE   = DEFAULT_SIZE,
  parameter int unsigned IDX_W  = $clog2(SIZE),
  parameter int unsigned ADDR_W = $clog2(SIZE * SIZE)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              advance_i,
  output logic [IDX_W-1:0]  i_o,
  output logic [IDX_W-1:0]  j_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(SIZE - 1);

  logic [IDX_W-1:0]  i_q, i_d;
  logic [IDX_W-1:0]  j_q, j_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              last_q, last_d;

  // The final cell wraps back to (0, 0) so the coordinates stay in range.
  always_comb begin
    i_d    = i_q;
    j_d    = j_q;
    addr_d = addr_q;
    last_d = last_q;
    if (clear_i) begin
      i_d    = '0;
      j_d    = '0;
      addr_d = '0;
      last_d = 1'(SIZE == 1);
    end else if (advance_i) begin
      if (j_q == MAX_IDX) begin
        j_d = '0;
        i_d = (i_q == MAX_IDX) ? '0 : i_q + IDX_W'(1);
      end else begin
        j_d = j_q + IDX_W'(1);
      end
      addr_d = ADDR_W'(i_d) * ADDR_W'(SIZE) + ADDR_W'(j_d);
      last_d = (i_d == MAX_IDX) && (j_d == MAX_IDX);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      i_q    <= '0;
      j_q    <= '0;
      addr_q <= '0;
      last_q <= 1'b0;
    end else begin
      i_q    <= i_d;
      j_q    <= j_d;
      addr_q <= addr_d;
      last_q <= last_d;
    end
  end

  assign i_o    = i_q;
  assign j_o    = j_q;
  assign addr_o = addr_q;
  assign last_o = last_q;

endmodule

// File: rtl/lenia_conv_scheduler.sv
// Sweeps the convolution engine over every cell of the Lenia world in raster
// order, writing each result to the result buffer, with abort and timeout.
module lenia_conv_scheduler
  import lenia_pkg::*;
#(
  parameter int unsigned SIZE    = DEFAULT_SIZE,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned IDX_W   = $clog2(SIZE),
  parameter int unsigned ADDR_W  = $clog2(SIZE * SIZE),
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                   S_AXI_ACLK,
  input  logic                   S_AXI_ARESETN,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [SWEEP_CNT_W-1:0] sweep_count,
  output logic                   conv_start,
  output logic [IDX_W-1:0]       conv_i,
  output logic [IDX_W-1:0]       conv_j,
  input  logic                   conv_ready,
  input  logic                   conv_done,
  input  logic [DATA_W-1:0]      conv_result,
  output logic                   res_we,
  output logic [ADDR_W-1:0]      res_addr,
  output logic [DATA_W-1:0]      res_wdata
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  state_e                   state_q, state_d;
  logic [TMO_W-1:0]         tmo_q, tmo_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     error_q, error_d;
  logic [SWEEP_CNT_W-1:0]   sweep_cnt_q, sweep_cnt_d;
  logic                     conv_start_q, conv_start_d;
  logic                     res_we_q, res_we_d;
  logic [ADDR_W-1:0]        res_addr_q, res_addr_d;
  logic [DATA_W-1:0]        res_wdata_q, res_wdata_d;

  logic                     rc_clear;
  logic                     rc_advance;
  logic [IDX_W-1:0]         rc_i;
  logic [IDX_W-1:0]         rc_j;
  logic [ADDR_W-1:0]        rc_addr;
  logic                     rc_last;

  lenia_raster_counter #(
    .SIZE   (SIZE),
    .IDX_W  (IDX_W),
    .ADDR_W (ADDR_W)
  ) u_raster (
    .clk_i     (S_AXI_ACLK),
    .rst_ni    (S_AXI_ARESETN),
    .clear_i   (rc_clear),
    .advance_i (rc_advance),
    .i_o       (rc_i),
    .j_o       (rc_j),
    .addr_o    (rc_addr),
    .last_o    (rc_last)
  );

  // Write-cycle outputs (res_we, done, sweep_count) are loaded on the
  // WAIT->WRITE edge so they line up with the WRITE state itself.
  always_comb begin
    state_d      = state_q;
    tmo_d        = tmo_q;
    error_d      = error_q;
    sweep_cnt_d  = sweep_cnt_q;
    res_addr_d   = res_addr_q;
    res_wdata_d  = res_wdata_q;
    conv_start_d = 1'b0;
    res_we_d     = 1'b0;
    done_d       = 1'b0;
    rc_clear     = 1'b0;
    rc_advance   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_ISSUE;
          tmo_d    = '0;
          error_d  = 1'b0;
          rc_clear = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (conv_ready) begin
          conv_start_d = 1'b1;
          tmo_d        = '0;
          state_d      = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (conv_done) begin
          res_wdata_d = conv_result;
          res_addr_d  = rc_addr;
          res_we_d    = 1'b1;
          state_d     = ST_WRITE;
          if (rc_last) begin
            done_d      = 1'b1;
            sweep_cnt_d = sweep_cnt_q + SWEEP_CNT_W'(1);
          end
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_WRITE: begin
        rc_advance = 1'b1;
        if (abort || rc_last) begin
          state_d = ST_IDLE;
        end else begin
          tmo_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state_q      <= ST_IDLE;
      tmo_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      sweep_cnt_q  <= '0;
      conv_start_q <= 1'b0;
      res_we_q     <= 1'b0;
      res_addr_q   <= '0;
      res_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      sweep_cnt_q  <= sweep_cnt_d;
      conv_start_q <= conv_start_d;
      res_we_q     <= res_we_d;
      res_addr_q   <= res_addr_d;
      res_wdata_q  <= res_wdata_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign sweep_count = sweep_cnt_q;
  assign conv_start  = conv_start_q;
  assign conv_i      = rc_i;
  assign conv_j      = rc_j;
  assign res_we      = res_we_q;
  assign res_addr    = res_addr_q;
  assign res_wdata   = res_wdata_q;

endmodule

// File: tb/tb_lenia_conv_scheduler.sv
// Bench for lenia_conv_scheduler on a 3x3 world with TIMEOUT=16: table-driven
// sweeps, abort/timeout/reset/wrap sequences and randomized engine timing.
module tb_lenia_conv_scheduler;

  localparam int unsigned SIZE = 3;
  localparam int unsigned NCELL = SIZE * SIZE;

  logic        clk = 1'b0;
  logic        S_AXI_ARESETN;
  logic        start;
  logic        abort;
  logic        busy, done, error;
  logic [15:0] sweep_count;
  logic        conv_start;
  logic [1:0]  conv_i, conv_j;
  logic        conv_ready = 1'b1;
  logic        conv_done = 1'b0;
  logic [31:0] conv_result = '0;
  logic        res_we;
  logic [3:0]  res_addr;
  logic [31:0] res_wdata;

  lenia_conv_scheduler #(
    .SIZE(SIZE), .DATA_W(32), .IDX_W(2), .ADDR_W(4), .TIMEOUT(16)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(S_AXI_ARESETN), .start(start), .abort(abort),
    .busy(busy), .done(done), .error(error), .sweep_count(sweep_count),
    .conv_start(conv_start), .conv_i(conv_i), .conv_j(conv_j),
    .conv_ready(conv_ready), .conv_done(conv_done), .conv_result(conv_result),
    .res_we(res_we), .res_addr(res_addr), .res_wdata(res_wdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Engine and ready-shaping configuration (written by the test only)
  int lat_cfg = 2;
  bit never_done = 1'b0;
  bit rand_mode = 1'b0;
  int gap_cell = 0;
  int gap_len = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Mock engine: lat = number of WAIT cycles including the conv_done cycle
  int eng_cnt = 0;
  int sum_lat = 0;
  logic [31:0] eng_held;
  logic [31:0] exp_by_addr [0:NCELL-1];
  always @(posedge clk) begin
    int lat;
    logic [31:0] d;
    int a;
    conv_done <= 1'b0;
    if (!S_AXI_ARESETN) begin
      eng_cnt = 0;
    end else if (conv_start && !never_done) begin
      lat = rand_mode ? int'($urandom_range(5, 2)) : lat_cfg;
      a = int'(conv_i) * SIZE + int'(conv_j);
      d = rand_mode ? $urandom : 32'(int'(conv_i) * 16 + int'(conv_j));
      if (a < NCELL) exp_by_addr[a] = d;
      sum_lat += lat;
      if (lat <= 2) begin
        conv_done <= 1'b1;
        conv_result <= d;
      end else begin
        eng_cnt = lat - 2;
        eng_held = d;
      end
    end else if (eng_cnt > 0) begin
      if (eng_cnt == 1) begin
        conv_done <= 1'b1;
        conv_result <= eng_held;
      end
      eng_cnt--;
    end
  end

  // Monitor: records writes/strobes, shapes conv_ready, checks per-event rules
  int wr_n = 0, cs_n = 0, done_cnt = 0, sum_gap = 0, hold_rem = 0;
  int t_issue = 0, t_done = 0, t_err = 0;
  int cs_cyc [0:NCELL-1];
  int we_cyc [0:NCELL-1];
  logic [3:0]  act_addr [0:511];
  logic [31:0] act_data [0:511];
  logic [3:0] cs_coord = '0;
  logic prev_cs = 1'b0, prev_busy = 1'b0, prev_err = 1'b0;
  always @(negedge clk) begin
    int g;
    if (hold_rem > 0) hold_rem--;
    else conv_ready = 1'b1;
    if (res_we) begin
      g = 0;
      if (rand_mode && res_addr != 4'(NCELL - 1)) g = int'($urandom_range(3, 0));
      else if (!rand_mode && gap_cell > 0 && int'(res_addr) == gap_cell - 1) g = gap_len;
      if (g > 0) begin
        conv_ready = 1'b0;
        hold_rem = g;
        sum_gap += g;
      end
      if (wr_n < 512) begin
        act_addr[wr_n] = res_addr;
        act_data[wr_n] = res_wdata;
      end
      wr_n++;
      if (int'(res_addr) < NCELL) we_cyc[res_addr] = cyc;
      check("coord_held", {conv_i, conv_j}, cs_coord);
      check("addr_map", res_addr, 64'(int'(conv_i) * SIZE + int'(conv_j)));
    end
    if (conv_start) begin
      check("cs_back_to_back", prev_cs, 0);
      cs_n++;
      cs_coord = {conv_i, conv_j};
      if (int'(conv_i) * SIZE + int'(conv_j) < NCELL) cs_cyc[int'(conv_i) * SIZE + int'(conv_j)] = cyc;
    end
    prev_cs = conv_start;
    if (busy && !prev_busy) t_issue = cyc;
    prev_busy = busy;
    if (done) begin
      done_cnt++;
      t_done = cyc;
      check("done_with_last_we", {res_we, res_addr}, {1'b1, 4'(NCELL - 1)});
    end
    if (error && !prev_err) t_err = cyc;
    prev_err = error;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  typedef struct {
    int lat;
    int gcell;
    int glen;
    int exp_cycles;
  } vec_t;

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int base, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      @(negedge clk);
      #1;
      if (done_cnt > base) ok = 1'b1;
    end
    check("done_seen", ok, 1);
  endtask

  task automatic check_writes(input int base, input bit use_model);
    logic [31:0] ed;
    check("write_count", wr_n - base, NCELL);
    for (int k = 0; k < int'(NCELL); k++) begin
      ed = use_model ? exp_by_addr[k] : 32'((k / SIZE) * 16 + (k % SIZE));
      check("write_addr", act_addr[base + k], k);
      check("write_data", act_data[base + k], ed);
    end
  endtask

  task automatic check_idle_after_done();
    @(negedge clk);
    #1;
    check("busy_after_done", busy, 0);
    check("done_single", done, 0);
  endtask

  initial begin
    vec_t vecs [4];
    bit ok;
    int b_wr, b_done, b_cs, b_lat, b_gap;
    logic [15:0] exp_sweeps;

    vecs[0] = '{lat: 2, gcell: 0, glen: 0, exp_cycles: 36};
    vecs[1] = '{lat: 3, gcell: 0, glen: 0, exp_cycles: 45};
    vecs[2] = '{lat: 2, gcell: 4, glen: 5, exp_cycles: 41};
    vecs[3] = '{lat: 4, gcell: 2, glen: 3, exp_cycles: 57};

    S_AXI_ARESETN = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    exp_sweeps = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_outputs", {busy, done, error, sweep_count, conv_start, conv_i, conv_j,
                            res_we, res_addr, res_wdata}, 0);
    S_AXI_ARESETN = 1'b1;
    @(negedge clk);
    #1;

    // Table-driven full sweeps with fixed latency and optional ready gap
    for (int t = 0; t < 4; t++) begin
      lat_cfg = vecs[t].lat;
      gap_cell = vecs[t].gcell;
      gap_len = vecs[t].glen;
      b_wr = wr_n;
      b_done = done_cnt;
      b_cs = cs_n;
      pulse_start();
      wait_done(b_done, ok);
      check("sweep_cycles", t_done - t_issue + 1, vecs[t].exp_cycles);
      check_writes(b_wr, 1'b0);
      check("issue_count", cs_n - b_cs, NCELL);
      check("issue_delay", cs_cyc[gap_cell > 0 ? gap_cell : 4] - we_cyc[(gap_cell > 0 ? gap_cell : 4) - 1],
            2 + vecs[t].glen);
      exp_sweeps = exp_sweeps + 16'd1;
      check("sweep_count", sweep_count, exp_sweeps);
      check_idle_after_done();
    end
    gap_cell = 0;
    gap_len = 0;

    // Abort in WAIT of cell (0,2) on the same cycle as conv_done
    lat_cfg = 2;
    b_wr = wr_n;
    b_done = done_cnt;
    ok = 1'b0;
    pulse_start();
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      #1;
      if (conv_done && conv_i == 2'd0 && conv_j == 2'd2) ok = 1'b1;
    end
    check("abort_point_found", ok, 1);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    #1;
    check("abort_busy", busy, 0);
    repeat (6) @(negedge clk);
    #1;
    check("abort_writes", wr_n - b_wr, 2);
    check("abort_no_done", done_cnt - b_done, 0);
    check("abort_sweep_count", sweep_count, exp_sweeps);
    check("abort_error", error, 0);

    // Engine never answers: error after 16 WAIT cycles
    never_done = 1'b1;
    b_wr = wr_n;
    b_done = done_cnt;
    ok = 1'b0;
    pulse_start();
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      #1;
      if (error) ok = 1'b1;
    end
    check("timeout_error", ok, 1);
    check("timeout_latency", t_err - t_issue, 17);
    check("timeout_busy", busy, 0);
    check("timeout_no_write", wr_n - b_wr, 0);
    check("timeout_no_done", done_cnt - b_done, 0);
    never_done = 1'b0;
    b_wr = wr_n;
    b_done = done_cnt;
    pulse_start();
    check("restart_clears_error", {busy, error}, 2'b10);
    wait_done(b_done, ok);
    check_writes(b_wr, 1'b0);
    exp_sweeps = exp_sweeps + 16'd1;
    check("restart_sweep_count", sweep_count, exp_sweeps);
    check_idle_after_done();

    // Start while busy is ignored, then a mid-sweep reset
    b_wr = wr_n;
    b_cs = cs_n;
    ok = 1'b0;
    pulse_start();
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      #1;
      if (cs_n - b_cs == 5) ok = 1'b1;
    end
    pulse_start();
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      #1;
      if (wr_n - b_wr == 5) ok = 1'b1;
    end
    check("busy_start_ignored", {ok, act_addr[b_wr + 4], busy}, {1'b1, 4'd4, 1'b1});
    S_AXI_ARESETN = 1'b0;
    @(posedge clk);
    #1 S_AXI_ARESETN = 1'b1;
    @(negedge clk);
    #1;
    check("midsweep_reset_outputs", {busy, done, error, sweep_count, conv_start, conv_i, conv_j,
                                     res_we, res_addr, res_wdata}, 0);
    exp_sweeps = '0;
    b_wr = wr_n;
    b_done = done_cnt;
    pulse_start();
    wait_done(b_done, ok);
    check_writes(b_wr, 1'b0);
    exp_sweeps = exp_sweeps + 16'd1;
    check("post_reset_sweep_count", sweep_count, exp_sweeps);
    check_idle_after_done();

    // Sweep counter wrap from 0xFFFF
    @(negedge clk);
    force dut.sweep_cnt_q = 16'hFFFF;
    @(posedge clk);
    #1 release dut.sweep_cnt_q;
    @(negedge clk);
    #1;
    exp_sweeps = 16'hFFFF;
    check("preload_sweep_count", sweep_count, exp_sweeps);
    b_done = done_cnt;
    pulse_start();
    wait_done(b_done, ok);
    exp_sweeps = exp_sweeps + 16'd1;
    check("wrap_sweep_count", sweep_count, exp_sweeps);
    check_idle_after_done();

    // Randomized latency, data and ready gaps against the cycle/data model
    rand_mode = 1'b1;
    for (int r = 0; r < 4; r++) begin
      b_wr = wr_n;
      b_done = done_cnt;
      b_lat = sum_lat;
      b_gap = sum_gap;
      pulse_start();
      wait_done(b_done, ok);
      check("rand_cycles", t_done - t_issue + 1, 2 * NCELL + (sum_lat - b_lat) + (sum_gap - b_gap));
      check_writes(b_wr, 1'b1);
      exp_sweeps = exp_sweeps + 16'd1;
      check("rand_sweep_count", sweep_count, exp_sweeps);
      check_idle_after_done();
      repeat (int'($urandom_range(3, 0))) @(negedge clk);
      #1;
    end
    rand_mode = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
